// File: rtl/mem_port_arbiter.sv
// Shares one backend memory port between instruction fetch (IF) and data memory (DM)
// requesters, with one outstanding transaction at a time and starvation-bounded DM priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_valid,
  output logic                    o_if_stall,
  input  logic                    i_dm_req,
  input  logic                    i_dm_we,
  input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_dm_be,
  output logic [DATA_WIDTH-1:0]   o_dm_rdata,
  output logic                    o_dm_valid,
  output logic                    o_dm_stall,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data,
  output logic                    o_busy,
  output logic [1:0]              o_dbg_state
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Backend handshake: a request transfers on the edge where o_mem_req_valid and
  // i_mem_req_ready are both high; payload stays stable while valid is high and ready low.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  owner_dm_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  if_elig, dm_elig;
  logic                  grant_if, grant_dm, complete;

  // A requester whose completion pulse is high this cycle is still holding its
  // old request, so it must not be granted again.
  assign if_elig = i_if_req & ~o_if_valid;
  assign dm_elig = i_dm_req & ~o_dm_valid;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    grant_if     = 1'b0;
    grant_dm     = 1'b0;
    complete     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_elig && dm_elig) begin
          grant_if = (starve_cnt_q == STARVE_MAX);
          grant_dm = ~grant_if;
        end else begin
          grant_if = if_elig;
          grant_dm = dm_elig;
        end
        if (grant_if) begin
          state_d      = ST_REQ;
          starve_cnt_d = '0;
        end else if (grant_dm) begin
          state_d = ST_REQ;
          if (if_elig && (starve_cnt_q < STARVE_MAX)) starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      ST_REQ: begin
        if (i_mem_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (i_mem_rsp_valid) begin
          state_d  = ST_IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      o_if_valid   <= 1'b0;
      o_dm_valid   <= 1'b0;
      o_if_rdata   <= '0;
      o_dm_rdata   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      o_if_valid   <= complete & ~owner_dm_q;
      o_dm_valid   <= complete & owner_dm_q;
      if (grant_if) begin
        owner_dm_q <= 1'b0;
        we_q       <= 1'b0;
        addr_q     <= i_if_addr;
        wdata_q    <= '0;
        be_q       <= '1;
      end else if (grant_dm) begin
        owner_dm_q <= 1'b1;
        we_q       <= i_dm_we;
        addr_q     <= i_dm_addr;
        wdata_q    <= i_dm_wdata;
        be_q       <= i_dm_be;
      end
      // Writes still complete through the response, but read data is kept.
      if (complete && !we_q) begin
        if (owner_dm_q) o_dm_rdata <= i_mem_rsp_data;
        else            o_if_rdata <= i_mem_rsp_data;
      end
    end
  end

  assign o_mem_req_valid = (state_q == ST_REQ);
  assign o_mem_we        = we_q;
  assign o_mem_addr      = addr_q;
  assign o_mem_wdata     = wdata_q;
  assign o_mem_be        = be_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_dbg_state     = state_q;
  assign o_if_stall      = if_elig;
  assign o_dm_stall      = dm_elig;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, a backend memory responder with an
// arbitration reference model, and a completion scoreboard with expected-data queues.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SL = 4;
  localparam int MEM_WORDS = 64;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_if_req = 1'b0;
  logic [AW-1:0] i_if_addr = '0;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_valid, o_if_stall;
  logic          i_dm_req = 1'b0;
  logic          i_dm_we = 1'b0;
  logic [AW-1:0] i_dm_addr = '0;
  logic [DW-1:0] i_dm_wdata = '0;
  logic [BW-1:0] i_dm_be = '0;
  logic [DW-1:0] o_dm_rdata;
  logic          o_dm_valid, o_dm_stall;
  logic          o_mem_req_valid;
  logic          i_mem_req_ready = 1'b0;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [BW-1:0] o_mem_be;
  logic          i_mem_rsp_valid = 1'b0;
  logic [DW-1:0] i_mem_rsp_data = '0;
  logic          o_busy;
  logic [1:0]    o_dbg_state;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be), .o_dm_rdata(o_dm_rdata),
    .o_dm_valid(o_dm_valid), .o_dm_stall(o_dm_stall),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } xact_t;

  logic [DW-1:0] bk_mem [MEM_WORDS];
  logic [DW-1:0] ref_mem[MEM_WORDS];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  logic [DW-1:0] dm_last_rd = '0;

  int ready_fix = 0;
  int rsp_fix = 0;
  bit spur_en = 1'b0;
  int last_req_cycles = 0;

  // ---------------- backend responder + arbitration model ----------------
  // Inputs for the next edge are decided at the negedge; the model tracks only
  // whether the port is free, waiting for acceptance, or waiting for a response.
  int    m_phase = 0;
  bit    m_done_if = 0, m_done_dm = 0, nx_done_if = 0, nx_done_dm = 0;
  int    m_cnt = 0;
  int    ready_cnt = 0, rsp_cnt = 0, req_cycles = 0;
  xact_t cur;
  logic [DW-1:0] rsp_hold;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      m_phase = 0; m_cnt = 0;
      m_done_if = 0; m_done_dm = 0; nx_done_if = 0; nx_done_dm = 0;
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'b0;
    end else begin
      m_done_if = nx_done_if;
      m_done_dm = nx_done_dm;
      nx_done_if = 0;
      nx_done_dm = 0;
      check("busy", o_busy, m_phase != 0);
      check("if_valid_pulse", o_if_valid, m_done_if);
      check("dm_valid_pulse", o_dm_valid, m_done_dm);
      check("mem_req_valid", o_mem_req_valid, m_phase == 1);
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_data  = $urandom;
      case (m_phase)
        0: begin
          bit el_if, el_dm, pick_if;
          if (spur_en) i_mem_rsp_valid = 1'($urandom_range(0, 1));
          el_if = i_if_req && !m_done_if;
          el_dm = i_dm_req && !m_done_dm;
          if (el_if || el_dm) begin
            pick_if = el_if && (!el_dm || m_cnt == SL);
            if (pick_if) begin
              cur.is_dm = 0; cur.we = 1'b0; cur.addr = i_if_addr;
              cur.wdata = '0; cur.be = '1;
              m_cnt = 0;
            end else begin
              cur.is_dm = 1; cur.we = i_dm_we; cur.addr = i_dm_addr;
              cur.wdata = i_dm_wdata; cur.be = i_dm_be;
              if (el_if && m_cnt < SL) m_cnt++;
            end
            m_phase = 1;
            req_cycles = 0;
            ready_cnt = (ready_fix >= 0) ? ready_fix : $urandom_range(0, 2);
          end
        end
        1: begin
          req_cycles++;
          check("mem_we", o_mem_we, cur.we);
          check("mem_addr", o_mem_addr, cur.addr);
          check("mem_be", o_mem_be, cur.be);
          if (cur.is_dm) check("mem_wdata", o_mem_wdata, cur.wdata);
          if (ready_cnt == 0) begin
            i_mem_req_ready = 1'b1;
            if (cur.we) begin
              for (int b = 0; b < BW; b++)
                if (cur.be[b]) bk_mem[cur.addr[7:2]][8*b +: 8] = cur.wdata[8*b +: 8];
            end
            rsp_hold = bk_mem[cur.addr[7:2]];
            last_req_cycles = req_cycles;
            rsp_cnt = (rsp_fix >= 0) ? rsp_fix : $urandom_range(0, 2);
            m_phase = 2;
          end else begin
            ready_cnt--;
          end
        end
        default: begin
          if (rsp_cnt == 0) begin
            i_mem_rsp_valid = 1'b1;
            if (!cur.we) i_mem_rsp_data = rsp_hold;
            if (cur.is_dm) nx_done_dm = 1; else nx_done_if = 1;
            m_phase = 0;
          end else begin
            rsp_cnt--;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_if_valid) begin
        if (if_exp_q.size() == 0) check("if_unexpected_valid", 1, 0);
        else check("if_rdata", o_if_rdata, if_exp_q.pop_front());
      end
      if (o_dm_valid) begin
        if (dm_exp_q.size() == 0) check("dm_unexpected_valid", 1, 0);
        else check("dm_rdata", o_dm_rdata, dm_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called just after a posedge) ----------------
  task automatic if_read(input logic [AW-1:0] addr, input bit hold, input int exp_lat);
    int cyc;
    bit got;
    cyc = 0; got = 0;
    i_if_req = 1'b1;
    i_if_addr = addr;
    if_exp_q.push_back(ref_mem[addr[7:2]]);
    while (!got && cyc < 200) begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_if_valid) got = 1;
      else check("if_stall_waiting", o_if_stall, 1);
    end
    check("if_completed", got, 1);
    check("if_stall_at_valid", o_if_stall, 0);
    if (exp_lat > 0) check("if_latency", cyc, exp_lat);
    if (!hold) i_if_req = 1'b0;
  endtask

  task automatic dm_access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [BW-1:0] be, input bit hold, input int exp_lat);
    int cyc;
    bit got;
    cyc = 0; got = 0;
    i_dm_req = 1'b1;
    i_dm_we = we;
    i_dm_addr = addr;
    i_dm_wdata = wdata;
    i_dm_be = be;
    if (we) begin
      for (int b = 0; b < BW; b++)
        if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      dm_last_rd = ref_mem[addr[7:2]];
    end
    dm_exp_q.push_back(dm_last_rd);
    while (!got && cyc < 200) begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_dm_valid) got = 1;
      else check("dm_stall_waiting", o_dm_stall, 1);
    end
    check("dm_completed", got, 1);
    check("dm_stall_at_valid", o_dm_stall, 0);
    if (exp_lat > 0) check("dm_latency", cyc, exp_lat);
    if (!hold) i_dm_req = 1'b0;
  endtask

  task automatic if_stream(input int n, input bit random_gaps);
    int gap;
    gap = random_gaps ? $urandom_range(0, 3) : 0;
    for (int k = 0; k < n; k++) begin
      int next_gap;
      logic [AW-1:0] a;
      repeat (gap) begin @(posedge i_clk); #1; end
      next_gap = random_gaps ? $urandom_range(0, 3) : 0;
      a = AW'($urandom_range(0, 31)) << 2;
      if_read(a, (next_gap == 0) && (k != n - 1), 0);
      gap = next_gap;
    end
  endtask

  task automatic dm_stream(input int n, input bit random_gaps);
    int gap;
    gap = random_gaps ? $urandom_range(0, 3) : 0;
    for (int k = 0; k < n; k++) begin
      int next_gap;
      logic [AW-1:0] a;
      repeat (gap) begin @(posedge i_clk); #1; end
      next_gap = random_gaps ? $urandom_range(0, 3) : 0;
      a = AW'($urandom_range(32, 63)) << 2;
      dm_access(1'($urandom_range(0, 1)), a, $urandom, BW'($urandom), (next_gap == 0) && (k != n - 1), 0);
      gap = next_gap;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    for (int i = 0; i < MEM_WORDS; i++) begin
      bk_mem[i] = $urandom;
      ref_mem[i] = bk_mem[i];
    end
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_state", o_dbg_state, 0);
    check("rst_mem_req_valid", o_mem_req_valid, 0);
    check("rst_if_valid", o_if_valid, 0);
    check("rst_dm_valid", o_dm_valid, 0);
    check("rst_if_rdata", o_if_rdata, 0);
    check("rst_dm_rdata", o_dm_rdata, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // Single IF read, zero-wait backend
    bk_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    ready_fix = 0; rsp_fix = 0;
    if_read(32'h0000_0010, 0, 3);

    // DM write with ready held low for two cycles
    ready_fix = 2;
    @(posedge i_clk); #1;
    dm_access(1'b1, 32'h40, 32'h1234_5678, 4'b0011, 0, 5);
    check("dm_req_hold_cycles", last_req_cycles, 3);

    // Back-to-back DM reads: second request presented in the first one's valid cycle
    ready_fix = 0;
    @(posedge i_clk); #1;
    dm_access(1'b0, 32'h80, '0, 4'hF, 1, 3);
    dm_access(1'b0, 32'h84, '0, 4'hF, 0, 4);

    // Both requesters continuously busy, zero-wait backend
    @(posedge i_clk); #1;
    fork
      if_stream(6, 0);
      dm_stream(6, 0);
    join

    // Randomised traffic with random backend waits and spurious idle responses
    ready_fix = -1; rsp_fix = -1; spur_en = 1;
    @(posedge i_clk); #1;
    fork
      if_stream(30, 1);
      dm_stream(30, 1);
    join
    spur_en = 0;
    repeat (4) @(posedge i_clk);
    #1;
    check("if_queue_drained", if_exp_q.size(), 0);
    check("dm_queue_drained", dm_exp_q.size(), 0);

    // Asynchronous reset while waiting for a response
    ready_fix = 0; rsp_fix = 20;
    i_if_req = 1'b1;
    i_if_addr = 32'h8;
    cnt = 0;
    while (m_phase != 2 && cnt < 20) begin @(posedge i_clk); #1; cnt++; end
    check("reached_rsp_phase", m_phase, 2);
    @(posedge i_clk); #3;
    i_reset_n = 1'b0;
    i_if_req = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_state", o_dbg_state, 0);
    check("arst_mem_req_valid", o_mem_req_valid, 0);
    check("arst_if_valid", o_if_valid, 0);
    check("arst_if_stall", o_if_stall, 0);
    check("arst_if_rdata", o_if_rdata, 0);
    check("arst_dm_rdata", o_dm_rdata, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    dm_last_rd = '0;

    // Late / spurious responses with no requests outstanding
    spur_en = 1;
    cnt = 0;
    repeat (10) begin
      @(posedge i_clk); #1;
      if (o_if_valid || o_dm_valid || o_busy) cnt++;
    end
    spur_en = 0;
    check("spurious_rsp_activity", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backend memory port between two requesters: instruction fetch (IF) and data memory access (DM).
- Serialises accesses with a single-outstanding-transaction FSM and returns read data to the requester that issued the access.
- Drives per-requester stall signals to the pipeline hazard logic.
- Sits between the fetch/memory stages and the external memory controller interface.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- STARVE_LIMIT, 4, maximum consecutive DM grants while IF is pending before IF is forced; range 1..15.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  IF read request; held until o_if_valid.
- i_if_addr  in  ADDR_WIDTH  IF read address.
- o_if_rdata  out  DATA_WIDTH  IF read data; valid with o_if_valid.
- o_if_valid  out  1  one-cycle IF completion pulse.
- o_if_stall  out  1  IF pending and not completing this cycle.
- i_dm_req  in  1  DM request; held until o_dm_valid.
- i_dm_we  in  1  1 = write, 0 = read.
- i_dm_addr  in  ADDR_WIDTH  DM address.
- i_dm_wdata  in  DATA_WIDTH  DM write data.
- i_dm_be  in  DATA_WIDTH/8  DM byte enables.
- o_dm_rdata  out  DATA_WIDTH  DM read data.
- o_dm_valid  out  1  one-cycle DM completion pulse.
- o_dm_stall  out  1  DM pending and not completing this cycle.
- o_mem_req_valid  out  1  backend request valid.
- i_mem_req_ready  in  1  backend accepts request.
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  backend payload.
- i_mem_rsp_valid  in  1  backend response; issued for reads and writes.
- i_mem_rsp_data  in  DATA_WIDTH  backend read data.
- o_busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, i_reset_n = 0):
  - State goes to IDLE.
  - All outputs, payload registers, grant register and the starvation counter go to 0.
  - An in-flight backend transaction is abandoned; the backend is reset by the same signal.
- States: IDLE, REQ, RSP.
- IDLE arbitration (combinational; grant registered at the clock edge):
  - Eligible requester = i_X_req AND NOT o_X_valid. A requester completing this cycle is masked, so it cannot be re-granted.
  - DM only, or IF only: grant it.
  - Both eligible: grant DM unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - On any grant: latch owner and payload (IF forces we = 0 and be = all ones), then go to REQ.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on a DM grant while IF is eligible.
  - Clears on an IF grant.
  - Otherwise holds.
- REQ:
  - o_mem_req_valid = 1 with the latched payload, held stable until i_mem_req_ready.
  - On ready, go to RSP.
- RSP:
  - o_mem_req_valid = 0.
  - On i_mem_rsp_valid, go to IDLE and register the completion: the owner's o_X_valid pulses for exactly the next cycle.
  - On a read, o_X_rdata loads i_mem_rsp_data. On a DM write, o_dm_rdata holds its previous value.
- o_X_rdata holds its value until the next read completion for that requester.
- i_mem_rsp_valid outside RSP is ignored.
- Minimum latency (request to valid pulse) is 3 cycles:
  - cycle 0: request seen in IDLE, granted at the edge.
  - cycle 1: REQ with ready = 1.
  - cycle 2: RSP with rsp_valid = 1.
  - cycle 3: o_X_valid pulse.
- Stalls (combinational): o_X_stall = i_X_req AND NOT o_X_valid.
- Requester protocol:
  - Dropping i_X_req or changing its payload before o_X_valid is illegal; behaviour after it is undefined.
  - The arbiter uses only latched payload after the grant.
- Request and completion in the same cycle: the completing requester is masked; the other requester may be granted in that cycle.

Test Plan:
- Single IF read, addr 0x0000_0010, ready = 1 immediately, rsp_valid 1 cycle after acceptance with data 0xDEAD_BEEF:
  - o_if_valid pulses at cycle 3 with o_if_rdata = 0xDEAD_BEEF.
  - o_if_stall is high in cycles 0-2 and low in cycle 3.
- DM write, addr 0x40, wdata 0x1234_5678, be = 4'b0011, ready held low for 2 cycles:
  - o_mem_req_valid is held for 3 cycles with stable payload.
  - o_dm_valid pulses once; o_dm_rdata is unchanged.
- IF and DM requesting continuously, STARVE_LIMIT = 4, zero-wait backend:
  - Grant order is DM, DM, DM, DM, IF, repeating.
  - IF is never stalled for more than 5 transactions.
- Back-to-back DM reads (DM re-requests in its own valid cycle):
  - No duplicate grant in the valid cycle.
  - The second access starts at the next IDLE evaluation.
  - o_dm_valid pulses exactly twice.
- Assert i_reset_n = 0 while in RSP:
  - State returns to IDLE immediately (asynchronously); all outputs are 0.
  - A late i_mem_rsp_valid = 1 after reset release produces no o_X_valid.
- Spurious i_mem_rsp_valid in IDLE with no requests:
  - No valid pulse; o_busy stays 0.
